mvm_tile_sequencer: RTL and testbench

// Runtime-configurable sequencer for an R x C matrix-vector multiply on a P-lane MAC array.

---
 rtl/mvm_tile_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_mvm_tile_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_tile_sequencer.sv
`default_nettype none
// ============================================================================
// mvm_tile_sequencer: walks P-row tiles of an R x C matrix-vector multiply and
// drains lane accumulators as a result stream. Optional macro: OUT_RELU_EN.
// Revision 1.0
// ============================================================================
module mvm_tile_sequencer #(
  parameter int ACC_W   = 16,
  parameter int P       = 2,
  parameter int MAX_N   = 64,
  parameter int ADDR_W  = 8,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [$clog2(MAX_N+1)-1:0] cfg_rows_i,
  input  logic [$clog2(MAX_N+1)-1:0] cfg_cols_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       cfg_err_o,
  output logic [ADDR_W-1:0]          w_bram_addr_o,
  output logic                       w_bram_en_o,
  output logic [ADDR_W-1:0]          x_bram_addr_o,
  output logic                       x_bram_en_o,
  output logic                       mac_clear_o,
  output logic                       mac_valid_o,
  output logic [P-1:0]               lane_mask_o,
  input  logic [P*ACC_W-1:0]         acc_in_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic [ACC_W-1:0]           res_data_o,
  output logic [$clog2(MAX_N)-1:0]   res_row_o
);

  localparam int CFG_W   = $clog2(MAX_N+1);
  localparam int ROW_W   = $clog2(MAX_N);
  localparam int RB_W    = CFG_W + 1;
  localparam int LANE_W  = (P > 1) ? $clog2(P) : 1;
  localparam int DRAIN_N = RD_LAT + MAC_LAT;
  localparam int DRN_W   = $clog2(DRAIN_N+1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_DRAIN = 3'd3,
    S_READ  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CFG_W-1:0]   rows_q, rows_d;
  logic [CFG_W-1:0]   cols_q, cols_d;
  logic [CFG_W-1:0]   col_q, col_d;
  logic               bad_q, bad_d;
  logic [DRN_W-1:0]   drn_q, drn_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic [RB_W-1:0]    row_base_q, row_base_d;
  logic [ADDR_W-1:0]  w_base_q, w_base_d;
  logic [RD_LAT-1:0]  vdl_q, vdl_d;

  logic               cfg_bad;
  logic               kill;
  logic               in_tile;
  logic               last_lane;
  logic               more_rows;
  logic [RB_W-1:0]    cur_row;
  logic [ACC_W-1:0]   lane_val;
  logic [ACC_W-1:0]   res_val;

  assign cfg_bad   = (cfg_rows_i == '0) || (cfg_cols_i == '0) ||
                     (cfg_rows_i > CFG_W'(MAX_N)) || (cfg_cols_i > CFG_W'(MAX_N));
  assign kill      = abort_i && (state_q != S_IDLE);
  assign in_tile   = !bad_q && (state_q inside {S_CLEAR, S_LOAD, S_DRAIN, S_READ});
  assign cur_row   = row_base_q + RB_W'(lane_q);
  // Masked lanes are always the top ones, so the first out-of-range row ends the tile.
  assign last_lane = ((cur_row + RB_W'(1)) >= {1'b0, rows_q}) || (lane_q == LANE_W'(P-1));
  assign more_rows = (row_base_q + RB_W'(P)) < {1'b0, rows_q};
  assign lane_val  = acc_in_i[lane_q*ACC_W +: ACC_W];

`ifdef OUT_RELU_EN
  assign res_val = lane_val[ACC_W-1] ? '0 : lane_val;
`else
  assign res_val = lane_val;
`endif

  for (genvar i = 0; i < P; i++) begin : g_lane
    assign lane_mask_o[i] = in_tile && ((row_base_q + RB_W'(i)) < {1'b0, rows_q});
  end

  if (RD_LAT == 1) begin : g_dl_one
    assign vdl_d = w_bram_en_o;
  end else begin : g_dl_shift
    assign vdl_d = {vdl_q[RD_LAT-2:0], w_bram_en_o};
  end

  assign busy_o      = (state_q != S_IDLE);
  assign x_bram_en_o = w_bram_en_o;
  assign mac_valid_o = vdl_q[RD_LAT-1];

  always_comb begin
    state_d       = state_q;
    rows_d        = rows_q;
    cols_d        = cols_q;
    col_d         = col_q;
    bad_d         = bad_q;
    drn_d         = drn_q;
    lane_d        = lane_q;
    row_base_d    = row_base_q;
    w_base_d      = w_base_q;
    done_o        = 1'b0;
    cfg_err_o     = 1'b0;
    w_bram_en_o   = 1'b0;
    w_bram_addr_o = '0;
    x_bram_addr_o = '0;
    mac_clear_o   = 1'b0;
    res_valid_o   = 1'b0;
    res_data_o    = '0;
    res_row_o     = '0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          rows_d     = cfg_rows_i;
          cols_d     = cfg_cols_i;
          bad_d      = cfg_bad;
          col_d      = '0;
          drn_d      = '0;
          lane_d     = '0;
          row_base_d = '0;
          w_base_d   = '0;
          state_d    = S_CLEAR;
        end
      end
      // A bad configuration still passes through CLEAR so its done lands one cycle later.
      S_CLEAR: begin
        mac_clear_o = !bad_q;
        col_d       = '0;
        state_d     = bad_q ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        w_bram_en_o   = 1'b1;
        w_bram_addr_o = w_base_q + ADDR_W'(col_q);
        x_bram_addr_o = ADDR_W'(col_q);
        if (col_q == (cols_q - CFG_W'(1))) begin
          drn_d   = '0;
          state_d = S_DRAIN;
        end else begin
          col_d = col_q + CFG_W'(1);
        end
      end
      S_DRAIN: begin
        if (drn_q == DRN_W'(DRAIN_N-1)) begin
          lane_d  = '0;
          state_d = S_READ;
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      S_READ: begin
        res_valid_o = 1'b1;
        res_data_o  = res_val;
        res_row_o   = ROW_W'(cur_row);
        if (res_ready_i) begin
          if (!last_lane) begin
            lane_d = lane_q + LANE_W'(1);
          end else if (more_rows) begin
            row_base_d = row_base_q + RB_W'(P);
            w_base_d   = w_base_q + ADDR_W'(cols_q);
            state_d    = S_CLEAR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_o    = 1'b1;
        cfg_err_o = bad_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (kill) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rows_q     <= '0;
      cols_q     <= '0;
      col_q      <= '0;
      bad_q      <= 1'b0;
      drn_q      <= '0;
      lane_q     <= '0;
      row_base_q <= '0;
      w_base_q   <= '0;
      vdl_q      <= '0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      col_q      <= col_d;
      bad_q      <= bad_d;
      drn_q      <= drn_d;
      lane_q     <= lane_d;
      row_base_q <= row_base_d;
      w_base_q   <= w_base_d;
      vdl_q      <= kill ? '0 : vdl_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mvm_tile_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mvm_tile_sequencer: directed jobs checked against a job-level model
// (address list, result list, mask per tile) plus literal cycle maps.
// Revision 1.0
// ============================================================================
module tb_mvm_tile_sequencer;
  localparam int P = 2, ACC_W = 16, MAX_N = 64, ADDR_W = 8, CW = 7, RW = 6;
`ifdef OUT_RELU_EN
  localparam logic [ACC_W-1:0] LIT_ROW0 = 16'h0000;
`else
  localparam logic [ACC_W-1:0] LIT_ROW0 = 16'hFFF9;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0, start = 1'b0, abort = 1'b0, res_ready = 1'b1;
  logic [CW-1:0] cfg_rows = '0, cfg_cols = '0;
  logic [P*ACC_W-1:0] acc_in = '0;
  logic busy, done, cfg_err, w_en, x_en, mac_clear, mac_valid, res_valid;
  logic [ADDR_W-1:0] w_addr, x_addr;
  logic [P-1:0] lane_mask;
  logic [ACC_W-1:0] res_data;
  logic [RW-1:0] res_row;

  mvm_tile_sequencer #(.ACC_W(ACC_W), .P(P), .MAX_N(MAX_N), .ADDR_W(ADDR_W),
                       .RD_LAT(1), .MAC_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
    .cfg_rows_i(cfg_rows), .cfg_cols_i(cfg_cols),
    .busy_o(busy), .done_o(done), .cfg_err_o(cfg_err),
    .w_bram_addr_o(w_addr), .w_bram_en_o(w_en),
    .x_bram_addr_o(x_addr), .x_bram_en_o(x_en),
    .mac_clear_o(mac_clear), .mac_valid_o(mac_valid), .lane_mask_o(lane_mask),
    .acc_in_i(acc_in), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .res_row_o(res_row)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  // Job model state
  int t0 = 0, jR = 0, jC = 0, tiles_seen = 0;
  bit jbad = 1'b0, mon_en = 1'b0, done_seen = 1'b0;
  int ew_q[$], ex_q[$], erow_q[$], wlog[$], hs_row[$];
  logic [ACC_W-1:0] edat_q[$], hs_dat[$];
  logic [P-1:0] mask_log[$];
  logic [63:0] m_clr, m_en, m_mv, m_hs, m_done, m_err, m_rv;

  function automatic logic [ACC_W-1:0] acc_val(input int r);
    if (r == 0) return 16'hFFF9;
    if (r == 1) return 16'd12;
    return (r % 2 != 0) ? ACC_W'(r * 100) : ACC_W'(-(r * 100));
  endfunction

  function automatic logic [ACC_W-1:0] exp_out(input int r);
    logic [ACC_W-1:0] v;
    v = acc_val(r);
`ifdef OUT_RELU_EN
    if ($signed(v) < 0) v = '0;
`endif
    return v;
  endfunction

  function automatic logic [P-1:0] exp_mask(input int t);
    logic [P-1:0] m;
    for (int i = 0; i < P; i++) m[i] = (t * P + i < jR);
    return m;
  endfunction

  // Compare process: every cycle against the job model.
  initial begin : mon
    logic pen, pab, pv, prd;
    logic [ACC_W-1:0] pdat;
    logic [RW-1:0] prow;
    int rel;
    pen = 0; pab = 0; pv = 0; prd = 0; pdat = '0; prow = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        rel = cyc - t0;
        if (rel >= 0 && rel < 64) begin
          m_clr[rel]  = mac_clear;
          m_en[rel]   = w_en;
          m_mv[rel]   = mac_valid;
          m_hs[rel]   = res_valid & res_ready;
          m_done[rel] = done;
          m_err[rel]  = cfg_err;
          m_rv[rel]   = res_valid;
        end
        if (w_en || x_en) chk("x_en_eq_w_en", x_en, w_en);
        if (w_en) begin
          chk("read_expected", ew_q.size() > 0, 1);
          if (ew_q.size() > 0) begin
            chk("w_addr", w_addr, ew_q.pop_front());
            chk("x_addr", x_addr, ex_q.pop_front());
          end
          wlog.push_back(int'(w_addr));
          chk("mask_in_load", lane_mask, exp_mask(tiles_seen - 1));
        end
        if (mac_clear) begin
          chk("mask_at_clear", lane_mask, exp_mask(tiles_seen));
          mask_log.push_back(lane_mask);
          for (int i = 0; i < P; i++)
            acc_in[i*ACC_W +: ACC_W] = (tiles_seen * P + i < jR) ? acc_val(tiles_seen * P + i) : 16'hBAD0;
          tiles_seen++;
        end
        if (busy || mac_valid || pen) chk("mac_valid", mac_valid, pen && !pab);
        if (pv && !prd && !pab) begin
          chk("hold_valid", res_valid, 1);
          chk("hold_data", res_data, pdat);
          chk("hold_row", res_row, prow);
        end
        if (res_valid && res_ready) begin
          hs_dat.push_back(res_data);
          hs_row.push_back(int'(res_row));
          chk("result_expected", erow_q.size() > 0, 1);
          if (erow_q.size() > 0) begin
            chk("res_row", res_row, erow_q.pop_front());
            chk("res_data", res_data, edat_q.pop_front());
          end
        end
        if (cfg_err) chk("cfg_err_needs_done", done, 1);
        if (done) begin
          done_seen = 1'b1;
          chk("cfg_err_at_done", cfg_err, jbad);
          chk("reads_left_at_done", ew_q.size(), 0);
          chk("results_left_at_done", erow_q.size(), 0);
        end
      end
      pen = w_en; pab = abort; pv = res_valid; prd = res_ready; pdat = res_data; prow = res_row;
    end
  end

  task automatic start_job(input int R, input int C);
    jR = R; jC = C;
    jbad = (R == 0 || C == 0 || R > MAX_N || C > MAX_N);
    ew_q.delete(); ex_q.delete(); erow_q.delete(); edat_q.delete();
    if (!jbad) begin
      for (int t = 0; t < (R + P - 1) / P; t++)
        for (int c = 0; c < C; c++) begin
          ew_q.push_back((t * C + c) % 256);
          ex_q.push_back(c % 256);
        end
      for (int r = 0; r < R; r++) begin
        erow_q.push_back(r);
        edat_q.push_back(exp_out(r));
      end
    end
    @(posedge clk); #1;
    t0 = cyc;
    m_clr = '0; m_en = '0; m_mv = '0; m_hs = '0; m_done = '0; m_err = '0; m_rv = '0;
    wlog.delete(); hs_row.delete(); hs_dat.delete(); mask_log.delete();
    tiles_seen = 0; done_seen = 1'b0;
    start = 1'b1; cfg_rows = CW'(R); cfg_cols = CW'(C);
  endtask

  // Drives ready/abort/start per relative cycle; returns early on done unless aborting.
  task automatic run(input int budget, input int st_from, input int st_len,
                     input int ab_at, input int poke_at);
    int rel;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      rel = cyc - t0;
      res_ready = !(rel >= st_from && rel < st_from + st_len);
      abort = (rel == ab_at);
      start = (rel == poke_at);
      if (rel == poke_at) begin
        cfg_rows = CW'(2);
        cfg_cols = CW'(9);
      end
      if (done_seen && ab_at < 0) break;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_w_en", w_en, 0);
    chk("rst_mac_valid", mac_valid, 0);
    chk("rst_mac_clear", mac_clear, 0);
    chk("rst_lane_mask", lane_mask, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_w_addr", w_addr, 0);
    @(posedge clk); #1;
    start = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // A: R=4 C=4, unstalled, stray start+cfg change while busy
    start_job(4, 4);
    run(60, -1, 0, -1, 7);
    chk("A_finished", done_seen, 1);
    @(negedge clk);
    chk("A_idle_after_done", busy, 0);
    chk("A_clear_cycles", m_clr, 64'h802);
    chk("A_en_cycles", m_en, 64'hF03C);
    chk("A_mv_cycles", m_mv, 64'h1E078);
    chk("A_hs_cycles", m_hs, 64'h180600);
    chk("A_done_cycle", m_done, 64'h200000);
    chk("A_row0_data", hs_dat[0], LIT_ROW0);
    chk("A_row1_data", hs_dat[1], 16'd12);

    // B: R=5 C=3, partial last tile
    start_job(5, 3);
    run(80, -1, 0, -1, -1);
    chk("B_finished", done_seen, 1);
    chk("B_tiles", mask_log.size(), 3);
    chk("B_tile2_mask", mask_log[2], 2'b01);
    chk("B_reads", wlog.size(), 9);
    chk("B_tile2_addr_first", wlog[6], 6);
    chk("B_tile2_addr_last", wlog[8], 8);
    chk("B_results", hs_row.size(), 5);
    chk("B_last_row", hs_row[4], 4);
    chk("B_done_cycle", m_done, 64'h800_0000);

    // C: backpressure on row 1 for 3 cycles
    start_job(4, 4);
    run(80, 10, 3, -1, -1);
    chk("C_finished", done_seen, 1);
    chk("C_results", hs_row.size(), 4);
    chk("C_hs_cycles", m_hs, 64'hC02200);
    chk("C_done_cycle", m_done, 64'h100_0000);

    // D: abort in LOAD col 2
    start_job(4, 4);
    run(4, -1, 0, 4, -1);
    @(negedge clk);
    chk("D_en_before_abort", w_en, 1);
    chk("D_col_at_abort", x_addr, 2);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("D_busy_after_abort", busy, 0);
    chk("D_en_after_abort", w_en, 0);
    chk("D_mv_after_abort", mac_valid, 0);
    repeat (12) @(posedge clk);
    chk("D_no_done", done_seen, 0);
    chk("D_no_results", m_rv, 0);

    // E: fresh job after abort
    start_job(4, 4);
    run(60, -1, 0, -1, -1);
    chk("E_finished", done_seen, 1);
    chk("E_results", hs_row.size(), 4);
    chk("E_done_cycle", m_done, 64'h200000);

    // F: zero rows
    start_job(0, 4);
    run(20, -1, 0, -1, -1);
    chk("F_done_cycle", m_done, 64'h4);
    chk("F_err_cycle", m_err, 64'h4);
    chk("F_no_reads", m_en, 0);
    chk("F_no_mv", m_mv, 0);
    chk("F_no_res", m_rv, 0);

    // G: too many columns
    start_job(4, MAX_N + 1);
    run(20, -1, 0, -1, -1);
    chk("G_done_cycle", m_done, 64'h4);
    chk("G_err_cycle", m_err, 64'h4);
    chk("G_no_reads", m_en, 0);
    chk("G_no_res", m_rv, 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
`default_nettype wire
